// File: rtl/ravg_if.sv
// Requester/consumer bundle for the shared running-average scheduler.
// master drives requests and consumer ready; slave is the scheduler.
interface ravg_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]             req_valid_i;
    logic [NUM_CH-1:0][DATA_W-1:0] req_data_i;
    logic [NUM_CH-1:0]             req_ready_o;
    logic [NUM_CH-1:0]             clear_i;
    logic                          avg_valid_o;
    logic [CH_W-1:0]               avg_ch_o;
    logic [DATA_W-1:0]             avg_data_o;
    logic                          avg_warm_o;
    logic                          out_ready_i;

    modport master (
        output req_valid_i, req_data_i, clear_i, out_ready_i,
        input  req_ready_o, avg_valid_o, avg_ch_o, avg_data_o, avg_warm_o
    );

    modport slave (
        input  req_valid_i, req_data_i, clear_i, out_ready_i,
        output req_ready_o, avg_valid_o, avg_ch_o, avg_data_o, avg_warm_o
    );
endinterface

// File: rtl/ravg_scheduler.sv
// Round-robin shared running-average datapath: one granted sample per cycle,
// per-channel (N-1)-deep history, registered channel-tagged result.
module ravg_lane #(
    parameter int N       = 4,
    parameter int DATA_W  = 32,
    parameter int SHIFT_N = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic [DATA_W+SHIFT_N-1:0] sum_o,
    output logic                      warm_o
);
    localparam logic [SHIFT_N-1:0] CNT_MAX = SHIFT_N'(N-1);

    logic [N-2:0][DATA_W-1:0] hist_q, hist_d;
    logic [SHIFT_N-1:0]       cnt_q, cnt_d;

    // Entries not yet written are zero, giving the zero-filled warm-up average.
    always_comb begin
        sum_o = {{SHIFT_N{1'b0}}, data_i};
        for (int k = 0; k < N-1; k++)
            sum_o = sum_o + {{SHIFT_N{1'b0}}, hist_q[k]};
        warm_o = (cnt_q == CNT_MAX);
    end

    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            hist_d = '0;
            cnt_d  = '0;
        end else if (push_i) begin
            hist_d[0] = data_i;
            for (int k = 1; k < N-1; k++)
                hist_d[k] = hist_q[k-1];
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module ravg_scheduler #(
    parameter int NUM_CH = 4,
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   reset,
    ravg_if.slave  bus
);
    localparam int SHIFT_N = $clog2(N);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int SUM_W   = DATA_W + SHIFT_N;

    logic                          stall;
    logic [NUM_CH-1:0]             grant;
    logic [CH_W-1:0]               gnt_idx;
    logic                          gnt_any;
    int                            idx;
    logic [NUM_CH-1:0][SUM_W-1:0]  lane_sum;
    logic [NUM_CH-1:0]             lane_warm;
    logic [SUM_W-1:0]              shifted;

    logic [CH_W-1:0]   rr_q, rr_d;
    logic              avg_valid_q, avg_valid_d;
    logic [CH_W-1:0]   avg_ch_q, avg_ch_d;
    logic [DATA_W-1:0] avg_data_q, avg_data_d;
    logic              avg_warm_q, avg_warm_d;

    assign stall = avg_valid_q && !bus.out_ready_i;

    // Cleared channels are never eligible, so clear wins over a same-cycle request.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (!stall) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = (int'(rr_q) + i) % NUM_CH;
                if (!gnt_any && bus.req_valid_i[idx] && !bus.clear_i[idx]) begin
                    gnt_any    = 1'b1;
                    gnt_idx    = CH_W'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        ravg_lane #(.N(N), .DATA_W(DATA_W), .SHIFT_N(SHIFT_N)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clear_i (bus.clear_i[c]),
            .push_i  (grant[c]),
            .data_i  (bus.req_data_i[c]),
            .sum_o   (lane_sum[c]),
            .warm_o  (lane_warm[c])
        );
    end

    always_comb begin
        rr_d        = rr_q;
        avg_valid_d = avg_valid_q;
        avg_ch_d    = avg_ch_q;
        avg_data_d  = avg_data_q;
        avg_warm_d  = avg_warm_q;
        shifted     = lane_sum[gnt_idx] >> SHIFT_N;
        if (!stall) begin
            avg_valid_d = gnt_any;
            if (gnt_any) begin
                avg_ch_d   = gnt_idx;
                avg_data_d = shifted[DATA_W-1:0];
                avg_warm_d = lane_warm[gnt_idx];
                rr_d       = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= '0;
            avg_valid_q <= 1'b0;
            avg_ch_q    <= '0;
            avg_data_q  <= '0;
            avg_warm_q  <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            avg_valid_q <= avg_valid_d;
            avg_ch_q    <= avg_ch_d;
            avg_data_q  <= avg_data_d;
            avg_warm_q  <= avg_warm_d;
        end
    end

    assign bus.req_ready_o = grant;
    assign bus.avg_valid_o = avg_valid_q;
    assign bus.avg_ch_o    = avg_ch_q;
    assign bus.avg_data_o  = avg_data_q;
    assign bus.avg_warm_o  = avg_warm_q;
endmodule

// File: tb/tb_ravg_scheduler.sv
// Bench for ravg_scheduler: behavioural model feeding a result scoreboard,
// a vector table for the single-channel window, and hand-written corner cases.
module tb_ravg_scheduler;
    localparam int NC = 4;
    localparam int N  = 4;

    typedef struct {
        int        ch;
        logic [31:0] data;
        bit        warm;
    } res_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] exp_avg;
        bit          exp_warm;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ravg_if #(.NUM_CH(NC), .DATA_W(32)) bus ();

    ravg_scheduler #(.NUM_CH(NC), .N(N), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mh [NC][N-1];
    int          mcnt [NC];
    int          mrr;
    bit          mvalid;
    res_t        sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*32-1:0] pack(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            mcnt[c] = 0;
            for (int k = 0; k < N-1; k++) mh[c][k] = '0;
        end
        mrr    = 0;
        mvalid = 0;
        sbq.delete();
    endtask

    // Reset with requests, clears and a stall all pending, to show reset dominates.
    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid_i = '1;
        bus.clear_i     = '1;
        bus.out_ready_i = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_valid", bus.avg_valid_o, 0);
        chk("rst_ch",    bus.avg_ch_o, 0);
        chk("rst_data",  bus.avg_data_o, 0);
        chk("rst_warm",  bus.avg_warm_o, 0);
        reset = 1'b0;
        bus.req_valid_i = '0;
        bus.clear_i     = '0;
        model_reset();
    endtask

    // One clock: drive at negedge, check grant, advance model, check result.
    task automatic cycle(input logic [NC-1:0] v, input logic [NC*32-1:0] d,
                         input logic [NC-1:0] clr, input bit ordy, output int g);
        logic [33:0] s;
        logic [33:0] sh;
        logic [NC-1:0] exp_rdy;
        bit stall;
        res_t r;
        bus.req_valid_i = v;
        bus.req_data_i  = d;
        bus.clear_i     = clr;
        bus.out_ready_i = ordy;
        #1;
        stall = mvalid && !ordy;
        g = -1;
        if (!stall)
            for (int i = 0; i < NC; i++) begin
                int c = (mrr + i) % NC;
                if (g < 0 && v[c] && !clr[c]) g = c;
            end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", bus.req_ready_o, exp_rdy);
        if (mvalid && ordy && sbq.size() > 0) void'(sbq.pop_front());
        if (g >= 0) begin
            s = {2'b0, d[g*32 +: 32]};
            for (int k = 0; k < N-1; k++) s = s + {2'b0, mh[g][k]};
            sh = s >> $clog2(N);
            r.ch = g; r.data = sh[31:0]; r.warm = (mcnt[g] == N-1);
            sbq.push_back(r);
            for (int k = N-2; k > 0; k--) mh[g][k] = mh[g][k-1];
            mh[g][0] = d[g*32 +: 32];
            if (mcnt[g] < N-1) mcnt[g]++;
            mrr = (g + 1) % NC;
            mvalid = 1;
        end else if (!stall) begin
            mvalid = 0;
        end
        for (int c = 0; c < NC; c++)
            if (clr[c]) begin
                mcnt[c] = 0;
                for (int k = 0; k < N-1; k++) mh[c][k] = '0;
            end
        @(posedge clk); @(negedge clk);
        chk("avg_valid", bus.avg_valid_o, mvalid);
        if (mvalid) begin
            if (sbq.size() == 0) chk("sb_empty", 1, 0);
            else begin
                chk("sb_ch",   bus.avg_ch_o,   sbq[0].ch);
                chk("sb_data", bus.avg_data_o, sbq[0].data);
                chk("sb_warm", bus.avg_warm_o, sbq[0].warm);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t win[5];
        int g;
        win[0] = '{32'd4,  32'd1,  1'b0};
        win[1] = '{32'd8,  32'd3,  1'b0};
        win[2] = '{32'd12, 32'd6,  1'b0};
        win[3] = '{32'd16, 32'd10, 1'b1};
        win[4] = '{32'd20, 32'd14, 1'b1};

        reset = 1'b1;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.clear_i     = '0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        do_reset();

        // Single-channel window
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0001, pack(win[i].d, 0, 0, 0), 4'b0000, 1'b1, g);
            chk("win_avg",  bus.avg_data_o, win[i].exp_avg);
            chk("win_warm", bus.avg_warm_o, win[i].exp_warm);
        end

        // Round-robin fairness and warm averages
        do_reset();
        for (int i = 0; i < 4*NC; i++) begin
            cycle(4'b1111, pack(100, 200, 300, 400), 4'b0000, 1'b1, g);
            chk("rr_grant", g, i % NC);
            if (i >= 3*NC) begin
                chk("rr_avg",  bus.avg_data_o, 100*(g+1));
                chk("rr_warm", bus.avg_warm_o, 1);
            end
        end

        // Backpressure
        do_reset();
        cycle(4'b0010, pack(0, 40, 0, 0), 4'b0000, 1'b1, g);
        chk("bp_first", bus.avg_data_o, 10);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0110, pack(0, 40, 50, 0), 4'b0000, 1'b0, g);
            chk("bp_ready", bus.req_ready_o, 0);
            chk("bp_data",  bus.avg_data_o, 10);
            chk("bp_ch",    bus.avg_ch_o, 1);
        end
        cycle(4'b0110, pack(0, 40, 50, 0), 4'b0000, 1'b1, g);
        chk("bp_resume_grant", g, 2);

        // Clear colliding with a request
        do_reset();
        for (int i = 0; i < 3; i++) cycle(4'b0001, pack(8, 0, 0, 0), 4'b0000, 1'b1, g);
        cycle(4'b0001, pack(8, 0, 0, 0), 4'b0001, 1'b1, g);
        chk("clr_nogrant", g, -1);
        cycle(4'b0001, pack(8, 0, 0, 0), 4'b0000, 1'b1, g);
        chk("clr_avg",  bus.avg_data_o, 2);
        chk("clr_warm", bus.avg_warm_o, 0);

        // Full-width samples must not wrap
        do_reset();
        for (int i = 0; i < 4; i++) cycle(4'b0001, pack(32'hFFFF_FFFF, 0, 0, 0), 4'b0000, 1'b1, g);
        chk("wide_avg",  bus.avg_data_o, 32'hFFFF_FFFF);
        chk("wide_warm", bus.avg_warm_o, 1);

        // Reset while stalled with a pending result
        do_reset();
        cycle(4'b0011, pack(4, 8, 0, 0), 4'b0000, 1'b1, g);
        cycle(4'b0011, pack(4, 8, 0, 0), 4'b0000, 1'b0, g);
        chk("mr_stalled", bus.avg_valid_o, 1);
        do_reset();
        cycle(4'b1111, pack(4, 8, 12, 16), 4'b0000, 1'b1, g);
        chk("mr_rr0", g, 0);
        chk("mr_avg", bus.avg_data_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
